// File: rtl/sevenseg_if.sv
// Display-path bundle between the MIPS debug/IO logic and the 7-segment scan controller.
// The master side produces the word to show; the slave side returns the decoder/anode drive.
interface sevenseg_if #(
    parameter int NUM_DIGITS = 8
);
    // load is a one-cycle strobe with no ready: the controller always accepts it,
    // and a newer load simply replaces a pending one that has not yet reached a frame wrap.
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [7:0]                dp_in;
    logic [7:0]                digit_en;
    logic [3:0]                hex;
    logic [7:0]                an;
    logic                      dp;
    logic                      blank;
    logic                      frame_done;

    modport master (
        output load, value, dp_in, digit_en,
        input  hex, an, dp, blank, frame_done
    );

    modport slave (
        input  load, value, dp_in, digit_en,
        output hex, an, dp, blank, frame_done
    );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: frame-synchronous value update,
// leading-zero blanking and an all-anodes-off guard interval at the start of every digit slot.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 100000,
    parameter int GUARD      = 16,
    parameter int LZ_BLANK   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    sevenseg_if.slave    bus,
    output logic         o_dbg_state
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int VAL_W = 4 * NUM_DIGITS;

    typedef enum logic {
        S_GUARD = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PRE_W-1:0]       r_presc;
    logic [IDX_W-1:0]       r_idx;
    logic [VAL_W-1:0]       r_act_val;
    logic [NUM_DIGITS-1:0]  r_act_dp;
    logic [VAL_W-1:0]       r_pend_val;
    logic [NUM_DIGITS-1:0]  r_pend_dp;
    logic                   r_pend_valid;

    logic                   w_tc;
    logic                   w_wrap;
    logic [NUM_DIGITS-1:0]  w_lz_dark;
    logic                   w_visible;
    logic [3:0]             w_nib;
    logic [7:0]             w_an_nxt;
    logic                   w_dp_nxt;

    assign w_tc   = (r_presc == PRE_W'(TICK_DIV - 1));
    assign w_wrap = w_tc && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_nib  = r_act_val[4*r_idx +: 4];

    assign o_dbg_state = (r_state == S_DRIVE);

    // Walk from the most significant digit down; a digit is a leading zero while
    // every nibble at or above it is zero. Digit 0 always shows.
    always_comb begin : lz_mask
        logic v_nz;
        v_nz      = 1'b0;
        w_lz_dark = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_nz         = v_nz | (|r_act_val[4*i +: 4]);
            w_lz_dark[i] = (LZ_BLANK != 0) && (i != 0) && !v_nz;
        end
    end

    assign w_visible = (r_state == S_DRIVE) && bus.digit_en[r_idx] && !w_lz_dark[r_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_GUARD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_an_nxt    = 8'hFF;
        w_dp_nxt    = 1'b1;
        case (r_state)
            S_GUARD: begin
                if (r_presc == PRE_W'(GUARD - 1)) begin
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (w_tc) begin
                    w_state_nxt = S_GUARD;
                end
            end
            default: w_state_nxt = S_GUARD;
        endcase
        if (w_visible) begin
            w_an_nxt[r_idx] = 1'b0;
            w_dp_nxt        = ~r_act_dp[r_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tc) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // A load landing on the frame-wrap edge bypasses pending so the newest word wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_val    <= '0;
            r_act_dp     <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_wrap) begin
            if (bus.load) begin
                r_act_val    <= bus.value;
                r_act_dp     <= bus.dp_in[NUM_DIGITS-1:0];
                r_pend_valid <= 1'b0;
            end else if (r_pend_valid) begin
                r_act_val    <= r_pend_val;
                r_act_dp     <= r_pend_dp;
                r_pend_valid <= 1'b0;
            end
        end else if (bus.load) begin
            r_pend_val   <= bus.value;
            r_pend_dp    <= bus.dp_in[NUM_DIGITS-1:0];
            r_pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an         <= 8'hFF;
            bus.hex        <= 4'h0;
            bus.dp         <= 1'b1;
            bus.blank      <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            bus.an         <= w_an_nxt;
            bus.hex        <= w_nib;
            bus.dp         <= w_dp_nxt;
            bus.blank      <= !w_visible;
            bus.frame_done <= w_wrap;
        end
    end
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Randomized and directed bench for sevenseg_scan_ctrl; two instances (LZ_BLANK=1 and 0)
// share stimulus and are compared every cycle against a frame-position reference model.
module tb_sevenseg_scan_ctrl;
  localparam int N  = 8;
  localparam int TD = 4;
  localparam int G  = 1;
  localparam int FR = N * TD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sevenseg_if #(.NUM_DIGITS(N)) bus_lz ();
  sevenseg_if #(.NUM_DIGITS(N)) bus_nz ();
  logic dbg_lz, dbg_nz;

  sevenseg_scan_ctrl #(.NUM_DIGITS(N), .TICK_DIV(TD), .GUARD(G), .LZ_BLANK(1)) u_dut_lz (
    .clk(clk), .rst_n(rst_n), .bus(bus_lz.slave), .o_dbg_state(dbg_lz)
  );
  sevenseg_scan_ctrl #(.NUM_DIGITS(N), .TICK_DIV(TD), .GUARD(G), .LZ_BLANK(0)) u_dut_nz (
    .clk(clk), .rst_n(rst_n), .bus(bus_nz.slave), .o_dbg_state(dbg_nz)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position p in 0..FR-1 within the frame; outputs seen after an edge describe the
  // position held just before that edge.
  int          m_p;
  logic [31:0] m_act, m_pend;
  logic [7:0]  m_adp, m_pdp;
  bit          m_pv;
  int          cyc;
  int          last_fd;
  logic [31:0] cur_val;
  logic [7:0]  cur_dp, cur_en;

  function automatic logic [14:0] model_outs(input bit lz, input int p, input logic [31:0] a,
                                             input logic [7:0] d, input logic [7:0] en);
    int         idx;
    int         ps;
    logic [3:0] nib;
    bit         lzd;
    bit         vis;
    logic [7:0] an;
    logic       dpo;
    idx = p / TD;
    ps  = p % TD;
    nib = 4'(a >> (4 * idx));
    lzd = lz && (idx > 0) && ((a >> (4 * idx)) == 0);
    vis = (ps >= G) && en[idx] && !lzd;
    an  = vis ? ~(8'd1 << idx) : 8'hFF;
    dpo = vis ? ~d[idx] : 1'b1;
    return {an, nib, dpo, !vis, (p == FR - 1)};
  endfunction

  function automatic logic [14:0] pack_lz();
    return {bus_lz.an, bus_lz.hex, bus_lz.dp, bus_lz.blank, bus_lz.frame_done};
  endfunction

  function automatic logic [14:0] pack_nz();
    return {bus_nz.an, bus_nz.hex, bus_nz.dp, bus_nz.blank, bus_nz.frame_done};
  endfunction

  task automatic model_reset();
    m_p = 0; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_pv = 0;
    last_fd = -1;
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drives one cycle of inputs, advances the model, compares after the edge.
  task automatic tick(input bit ld, input logic [31:0] v, input logic [7:0] d, input logic [7:0] e);
    logic [14:0] exp_lz, exp_nz;
    bus_lz.load = ld; bus_lz.value = v; bus_lz.dp_in = d; bus_lz.digit_en = e;
    bus_nz.load = ld; bus_nz.value = v; bus_nz.dp_in = d; bus_nz.digit_en = e;
    exp_lz = model_outs(1'b1, m_p, m_act, m_adp, e);
    exp_nz = model_outs(1'b0, m_p, m_act, m_adp, e);
    if (m_p == FR - 1) begin
      if (ld) begin
        m_act = v; m_adp = d; m_pv = 0;
      end else if (m_pv) begin
        m_act = m_pend; m_adp = m_pdp; m_pv = 0;
      end
    end else if (ld) begin
      m_pend = v; m_pdp = d; m_pv = 1;
    end
    m_p = (m_p + 1) % FR;
    cyc++;
    @(posedge clk);
    @(negedge clk);
    check("outs_lz", 32'(pack_lz()), 32'(exp_lz));
    check("outs_nolz", 32'(pack_nz()), 32'(exp_nz));
    if (bus_lz.frame_done) begin
      if (last_fd >= 0) check("fd_period", last_fd + FR, cyc);
      last_fd = cyc;
    end
    bus_lz.load = 1'b0;
    bus_nz.load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, cur_val, cur_dp, cur_en);
  endtask

  task automatic load_word(input logic [31:0] v, input logic [7:0] d, input logic [7:0] e);
    cur_val = v; cur_dp = d; cur_en = e;
    tick(1'b1, v, d, e);
  endtask

  task automatic idle_until_pos(input int p);
    int budget;
    budget = 0;
    while (m_p != p && budget < 2 * FR) begin
      idle(1);
      budget++;
    end
    check("pos_reached", m_p, p);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_an"},    32'(bus_lz.an), 32'hFF);
    check({tag, "_hex"},   32'(bus_lz.hex), 32'h0);
    check({tag, "_dp"},    32'(bus_lz.dp), 32'h1);
    check({tag, "_blank"}, 32'(bus_lz.blank), 32'h1);
    check({tag, "_fd"},    32'(bus_lz.frame_done), 32'h0);
  endtask

  // Reset asserted while a digit is lit, checked before any clock edge, then released.
  task automatic reset_mid_drive();
    int budget;
    budget = 0;
    while ((pack_lz() >> 7) == 15'h00FF && budget < 2 * FR) begin
      idle(1);
      budget++;
    end
    check("mid_drive_lit", 32'((pack_lz() >> 7) != 15'h00FF), 32'h1);
    bus_lz.load = 1'b0; bus_nz.load = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst_async");
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rv;
    cyc = 0;
    cur_val = '0; cur_dp = '0; cur_en = 8'hFF;
    bus_lz.load = 0; bus_lz.value = '0; bus_lz.dp_in = '0; bus_lz.digit_en = 8'hFF;
    bus_nz.load = 0; bus_nz.value = '0; bus_nz.dp_in = '0; bus_nz.digit_en = 8'hFF;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outs("rst");
    rst_n = 1'b1;

    // Full display; new word only becomes active after the next frame wrap.
    idle(5);
    load_word(32'h1234ABCD, 8'h00, 8'hFF);
    idle(3 * FR);

    // Leading-zero blanking and zero value.
    load_word(32'h000000F0, 8'h00, 8'hFF);
    idle(2 * FR + 3);
    load_word(32'h00000000, 8'hFF, 8'hFF);
    idle(2 * FR);

    // Load / wrap collision: 3s must win and appear alone in the next frame.
    idle_until_pos(5);
    load_word(32'h11111111, 8'h00, 8'hFF);
    idle(1);
    load_word(32'h22222222, 8'h00, 8'hFF);
    idle_until_pos(FR - 1);
    load_word(32'h33333333, 8'h00, 8'hFF);
    for (int k = 0; k < FR; k++) begin
      idle(1);
      if (!bus_lz.blank) check("collision_hex", 32'(bus_lz.hex), 32'h3);
    end

    // Enables and decimal points.
    load_word(32'h87654321, 8'h05, 8'h0F);
    idle(3 * FR);

    reset_mid_drive();
    idle(2 * FR);

    // Randomized traffic: sparse loads, varied leading zeros, live enable changes.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) cur_en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      if ($urandom_range(0, 7) == 0) begin
        rv = $urandom;
        rv = rv >> (4 * $urandom_range(0, 8));
        load_word(rv, 8'($urandom), cur_en);
      end else begin
        idle(1);
      end
    end

    reset_mid_drive();
    idle(FR + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
